flimatch: RTL and testbench

Inverse of the FLI immediate generator. Accepts a NaN-boxed floating-point register value and a format code, and reports whether the value equals one of the 32 Zfa `fli` constants; if it does, it returns the 5-bit index. The block sits beside the FPU as a pipelined, valid/ready helper for the decoder-side compressor and the trace/verification hooks. It is a 2-stage pipeline with backpressure.

---
 rtl/fli_pkg.sv | 49 ++++
 rtl/fliunpack.sv | 117 +++++++++++
 rtl/flimatch.sv | 140 ++++++++++++++
 tb/tb_flimatch.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fli_pkg.sv
// fli_pkg: shared constants and types for the FLI constant matcher.
// Format codes, index names, class enum and per-format field geometry.
package fli_pkg;

    localparam logic [1:0] FMT_S = 2'b00;
    localparam logic [1:0] FMT_D = 2'b01;
    localparam logic [1:0] FMT_H = 2'b10;
    localparam logic [1:0] FMT_Q = 2'b11;

    localparam logic [4:0] FLI_NEG1 = 5'd0;
    localparam logic [4:0] FLI_MINN = 5'd1;
    localparam logic [4:0] FLI_ONE  = 5'd16;
    localparam logic [4:0] FLI_INF  = 5'd30;
    localparam logic [4:0] FLI_QNAN = 5'd31;

    typedef enum logic [2:0] {
        FC_ZERO,
        FC_SUB,
        FC_NORM,
        FC_INF,
        FC_NAN
    } fcls_e;

    localparam int S_W = 32;
    localparam int S_BIAS = 127;
    localparam int D_W = 64;
    localparam int D_BIAS = 1023;
    localparam int H_W = 16;
    localparam int H_BIAS = 15;
    localparam int Q_W = 128;
    localparam int Q_BIAS = 16383;

    // Widest format; fractions are left-aligned into MANT_W bits.
    localparam int XW = 128;
    localparam int MANT_W = 112;

    // Stage-1 bundle: everything the index mapper needs.
    typedef struct packed {
        logic               sup;
        logic               boxok;
        logic               sign;
        fcls_e              cls;
        logic [1:0]         m;
        logic               rz;
        logic               minn;
        logic signed [16:0] e;
    } s1_t;

endpackage

// File: rtl/fliunpack.sv
// fliunpack: per-format field extraction and NaN-box check.
// Subnormals are normalised so 2^e matching works for half too.
module fliunpack
    import fli_pkg::*;
#(
    parameter int FLEN          = 64,
    parameter bit ZFH_SUPPORTED = 1'b1,
    parameter bit D_SUPPORTED   = 1'b1,
    parameter bit Q_SUPPORTED   = 1'b1
) (
    input  logic [FLEN-1:0] x_i,
    input  logic [1:0]      fmt_i,
    output s1_t             f_o
);

    logic [XW-1:0]     xw;
    logic [14:0]       expf;
    logic [14:0]       emax;
    logic [MANT_W-1:0] mant;
    logic [MANT_W-1:0] sub_m;
    logic              sign;
    logic              sup;
    logic              boxok;
    logic              found;
    int                w;
    int                bias;
    int                lz;

    // Decode the selected format into sign/exponent/left-aligned fraction.
    always_comb begin
        xw = '0;
        xw[FLEN-1:0] = x_i;
        w = S_W;
        bias = S_BIAS;
        sign = 1'b0;
        expf = '0;
        emax = '0;
        mant = '0;
        sup = 1'b0;
        unique case (fmt_i)
            FMT_S: begin
                w = S_W;
                bias = S_BIAS;
                sign = xw[31];
                expf = 15'(xw[30:23]);
                emax = 15'h00FF;
                mant = {xw[22:0], 89'b0};
                sup = 1'b1;
            end
            FMT_D: begin
                w = D_W;
                bias = D_BIAS;
                sign = xw[63];
                expf = 15'(xw[62:52]);
                emax = 15'h07FF;
                mant = {xw[51:0], 60'b0};
                sup = D_SUPPORTED && (FLEN >= 64);
            end
            FMT_H: begin
                w = H_W;
                bias = H_BIAS;
                sign = xw[15];
                expf = 15'(xw[14:10]);
                emax = 15'h001F;
                mant = {xw[9:0], 102'b0};
                sup = ZFH_SUPPORTED;
            end
            FMT_Q: begin
                w = Q_W;
                bias = Q_BIAS;
                sign = xw[127];
                expf = xw[126:112];
                emax = 15'h7FFF;
                mant = xw[111:0];
                sup = Q_SUPPORTED && (FLEN >= 128);
            end
        endcase
    end

    // Box check, leading-one search and classification.
    always_comb begin
        boxok = 1'b1;
        for (int i = 0; i < XW; i++) begin
            if (i >= w && i < FLEN && !xw[i]) boxok = 1'b0;
        end
        lz = 0;
        found = 1'b0;
        for (int i = MANT_W - 1; i >= 0; i--) begin
            if (!found && mant[i]) begin
                lz = MANT_W - 1 - i;
                found = 1'b1;
            end
        end
        sub_m = mant << (lz + 1);
        f_o.sup = sup;
        f_o.boxok = boxok;
        f_o.sign = sign;
        f_o.minn = (expf == 15'd1) && (mant == '0);
        f_o.m = mant[MANT_W-1:MANT_W-2];
        f_o.rz = ~|mant[MANT_W-3:0];
        f_o.e = '0;
        if (expf == '0) begin
            f_o.cls = (mant == '0) ? FC_ZERO : FC_SUB;
            if (mant != '0) begin
                f_o.e = -17'(bias) - 17'(lz);
                f_o.m = sub_m[MANT_W-1:MANT_W-2];
                f_o.rz = ~|sub_m[MANT_W-3:0];
            end
        end else if (expf == emax) begin
            f_o.cls = (mant == '0) ? FC_INF : FC_NAN;
        end else begin
            f_o.cls = FC_NORM;
            f_o.e = $signed({2'b00, expf}) - 17'(bias);
        end
    end

endmodule

// File: rtl/flimatch.sv
// flimatch: 2-stage valid/ready matcher of FP values to fli indices.
// Stage 1 registers unpacked fields, stage 2 registers Hit/Idx.
module flimatch
    import fli_pkg::*;
#(
    parameter int FLEN          = 64,
    parameter bit ZFH_SUPPORTED = 1'b1,
    parameter bit D_SUPPORTED   = 1'b1,
    parameter bit Q_SUPPORTED   = 1'b1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            InValid,
    output logic            InReady,
    input  logic [FLEN-1:0] X,
    input  logic [1:0]      Fmt,
    output logic            OutValid,
    input  logic            OutReady,
    output logic            Hit,
    output logic [4:0]      Idx
);

    s1_t        u;
    s1_t        s1_q, s1_d;
    logic       s1v_q, s1v_d;
    logic       ov_q, ov_d;
    logic       hit_q, hit_d;
    logic [4:0] idx_q, idx_d;
    logic       adv1, adv2;
    logic       hit_m, ok, fin, pw;
    logic [4:0] idx_m, cand;

    fliunpack #(
        .FLEN         (FLEN),
        .ZFH_SUPPORTED(ZFH_SUPPORTED),
        .D_SUPPORTED  (D_SUPPORTED),
        .Q_SUPPORTED  (Q_SUPPORTED)
    ) u_unpack (
        .x_i  (X),
        .fmt_i(Fmt),
        .f_o  (u)
    );

    assign adv2 = ~ov_q | OutReady;
    assign adv1 = ~s1v_q | adv2;
    assign InReady = adv1;
    assign OutValid = ov_q;
    assign Hit = hit_q;
    assign Idx = idx_q;

    // Map registered stage-1 fields onto the fli index table.
    always_comb begin
        hit_m = 1'b0;
        idx_m = '0;
        ok = 1'b0;
        cand = '0;
        fin = (s1_q.cls == FC_NORM || s1_q.cls == FC_SUB) && s1_q.rz;
        pw = fin && (s1_q.m == 2'b00);
        if (s1_q.sup) begin
            if (!s1_q.boxok) begin
                ok = 1'b1;
                cand = FLI_QNAN;
            end else if (s1_q.cls == FC_INF) begin
                ok = !s1_q.sign;
                cand = FLI_INF;
            end else if (s1_q.cls == FC_NAN) begin
                ok = !s1_q.sign && s1_q.m == 2'b10 && s1_q.rz;
                cand = FLI_QNAN;
            end else if (s1_q.sign) begin
                ok = pw && s1_q.e == '0;
                cand = FLI_NEG1;
            end else if (s1_q.minn) begin
                ok = 1'b1;
                cand = FLI_MINN;
            end else begin
                case (int'(s1_q.e))
                    -16: begin ok = pw; cand = 5'd2; end
                    -15: begin ok = pw; cand = 5'd3; end
                    -8:  begin ok = pw; cand = 5'd4; end
                    -7:  begin ok = pw; cand = 5'd5; end
                    -4:  begin ok = pw; cand = 5'd6; end
                    -3:  begin ok = pw; cand = 5'd7; end
                    -2:  begin ok = fin; cand = 5'd8 + 5'(s1_q.m); end
                    -1:  begin ok = fin; cand = 5'd12 + 5'(s1_q.m); end
                    0:   begin ok = fin; cand = FLI_ONE + 5'(s1_q.m); end
                    1: begin
                        ok = fin && s1_q.m != 2'b11;
                        cand = 5'd20 + 5'(s1_q.m);
                    end
                    2:   begin ok = pw; cand = 5'd23; end
                    3:   begin ok = pw; cand = 5'd24; end
                    4:   begin ok = pw; cand = 5'd25; end
                    7:   begin ok = pw; cand = 5'd26; end
                    8:   begin ok = pw; cand = 5'd27; end
                    15:  begin ok = pw; cand = 5'd28; end
                    16:  begin ok = pw; cand = 5'd29; end
                    default: begin ok = 1'b0; cand = '0; end
                endcase
            end
        end
        hit_m = ok;
        idx_m = ok ? cand : '0;
    end

    // Pipeline advance: each stage loads only when its successor frees up.
    always_comb begin
        s1v_d = s1v_q;
        s1_d = s1_q;
        ov_d = ov_q;
        hit_d = hit_q;
        idx_d = idx_q;
        if (adv1) begin
            s1v_d = InValid;
            s1_d = u;
        end
        if (adv2) begin
            ov_d = s1v_q;
            hit_d = s1v_q & hit_m;
            idx_d = s1v_q ? idx_m : '0;
        end
    end

    // State registers with synchronous flush.
    always_ff @(posedge clk) begin
        if (reset) begin
            s1v_q <= 1'b0;
            s1_q <= '0;
            ov_q <= 1'b0;
            hit_q <= 1'b0;
            idx_q <= '0;
        end else begin
            s1v_q <= s1v_d;
            s1_q <= s1_d;
            ov_q <= ov_d;
            hit_q <= hit_d;
            idx_q <= idx_d;
        end
    end

endmodule

// File: tb/tb_flimatch.sv
// tb_flimatch: scoreboard bench for flimatch with FLEN=64.
// Reference model encodes the fli table per format and searches it.
module tb_flimatch;

    localparam int FLEN = 64;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic            InValid = 1'b0;
    logic            InReady;
    logic [FLEN-1:0] X = '0;
    logic [1:0]      Fmt = 2'b00;
    logic            OutValid;
    logic            OutReady = 1'b1;
    logic            Hit;
    logic [4:0]      Idx;

    flimatch #(
        .FLEN         (FLEN),
        .ZFH_SUPPORTED(1'b1),
        .D_SUPPORTED  (1'b1),
        .Q_SUPPORTED  (1'b1)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .InValid (InValid),
        .InReady (InReady),
        .X       (X),
        .Fmt     (Fmt),
        .OutValid(OutValid),
        .OutReady(OutReady),
        .Hit     (Hit),
        .Idx     (Idx)
    );

    always #5 clk = ~clk;

    int         errors = 0;
    int         checks = 0;
    logic [5:0] exp_q[$];
    int         inflight = 0;
    int         rdy_mode = 0;
    int         rdy_cnt = 0;
    bit         prev_stall = 0;
    logic       prev_hit = 0;
    logic [4:0] prev_idx = 0;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    // Field geometry per format code (quad is wider than FLEN here).
    function automatic void fpar(input int f, output int w, output int mw,
                                 output int ew, output int bias);
        case (f)
            0: begin w = 32; mw = 23; ew = 8; bias = 127; end
            1: begin w = 64; mw = 52; ew = 11; bias = 1023; end
            2: begin w = 16; mw = 10; ew = 5; bias = 15; end
            default: begin w = 128; mw = 112; ew = 15; bias = 16383; end
        endcase
    endfunction

    // Value of table entry i as (-1)^s * 2^e * (1 + m/4).
    function automatic void fval(input int i, output int s, output int e,
                                 output int m);
        int pl[6] = '{-16, -15, -8, -7, -4, -3};
        int ph[7] = '{2, 3, 4, 7, 8, 15, 16};
        s = 0; e = 0; m = 0;
        if (i == 0) s = 1;
        else if (i >= 2 && i <= 7) e = pl[i-2];
        else if (i >= 8 && i <= 19) begin e = (i - 8) / 4 - 2; m = (i - 8) % 4; end
        else if (i >= 20 && i <= 22) begin e = 1; m = i - 20; end
        else if (i >= 23 && i <= 29) e = ph[i-23];
    endfunction

    // Encode table entry i in format f; returns 0 if unrepresentable.
    function automatic bit enc(input int f, input int i, output logic [63:0] v);
        int w, mw, ew, bias, s, e, m, be;
        logic [63:0] emaxf;
        v = '0;
        if (f == 3) return 1'b0;
        fpar(f, w, mw, ew, bias);
        emaxf = (64'(1) << ew) - 1;
        if (i == 30) begin v = emaxf << mw; return 1'b1; end
        if (i == 31) begin v = (emaxf << mw) | (64'(1) << (mw - 1)); return 1'b1; end
        if (i == 1) begin v = 64'(1) << mw; return 1'b1; end
        fval(i, s, e, m);
        be = e + bias;
        if (64'(be) >= emaxf) return 1'b0;
        if (be >= 1) begin
            v = (64'(s) << (w - 1)) | (64'(be) << mw) | (64'(m) << (mw - 2));
        end else begin
            if (be + mw - 1 < 0 || m != 0) return 1'b0;
            v = (64'(s) << (w - 1)) | (64'(1) << (be + mw - 1));
        end
        return 1'b1;
    endfunction

    function automatic int fw(input int f);
        int w, mw, ew, bias;
        fpar(f, w, mw, ew, bias);
        return (w > 64) ? 64 : w;
    endfunction

    function automatic logic [63:0] box(input int f, input logic [63:0] v);
        int w = fw(f);
        if (w >= 64) return v;
        return v | ~((64'(1) << w) - 1);
    endfunction

    // Reference: unsupported -> miss, bad box -> 31, else table lookup.
    function automatic logic [5:0] model(input int f, input logic [63:0] x);
        int w;
        logic [63:0] val, v;
        if (f == 3) return 6'd0;
        w = fw(f);
        if (w < 64 && (x >> w) != ((64'(1) << (64 - w)) - 1)) return {1'b1, 5'd31};
        val = (w == 64) ? x : (x & ((64'(1) << w) - 1));
        for (int i = 0; i < 32; i++) begin
            if (enc(f, i, v) && v == val) return {1'b1, 5'(i)};
        end
        return 6'd0;
    endfunction

    task automatic send(input logic [1:0] f, input logic [63:0] x,
                        input logic [5:0] e);
        Fmt = f;
        X = x;
        InValid = 1'b1;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (InReady) begin
                exp_q.push_back(e);
                @(posedge clk);
                #1;
                return;
            end
            @(posedge clk);
            #1;
        end
        chk("accept_timeout", 64'd0, 64'd1);
    endtask

    task automatic drain();
        InValid = 1'b0;
        for (int k = 0; k < 500; k++) begin
            if (exp_q.size() == 0) break;
            @(posedge clk);
        end
        @(posedge clk);
        #1;
        chk("drain", 64'(exp_q.size()), 64'd0);
    endtask

    // OutReady generator: always, 1-0-0 pattern, random, or held low.
    always @(posedge clk) begin
        #1;
        case (rdy_mode)
            0: OutReady = 1'b1;
            1: begin OutReady = (rdy_cnt % 3 == 0); rdy_cnt++; end
            2: OutReady = 1'($urandom_range(0, 1));
            default: OutReady = 1'b0;
        endcase
    end

    // Monitor: scoreboard pop, InReady rule and stall stability.
    always @(negedge clk) begin
        logic [5:0] e;
        if (reset) begin
            inflight = 0;
            prev_stall = 0;
        end else begin
            if (prev_stall) begin
                chk("stall_valid", 64'(OutValid), 64'd1);
                chk("stall_hit", 64'(Hit), 64'(prev_hit));
                chk("stall_idx", 64'(Idx), 64'(prev_idx));
            end
            chk("in_ready", 64'(InReady),
                64'(!(inflight == 2 && OutValid && !OutReady)));
            if (OutValid && OutReady) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_out", 64'({Hit, Idx}), 64'h100);
                end else begin
                    e = exp_q.pop_front();
                    chk("result", 64'({Hit, Idx}), 64'(e));
                end
            end
            prev_stall = OutValid && !OutReady;
            prev_hit = Hit;
            prev_idx = Idx;
            inflight += int'(InValid && InReady) - int'(OutValid && OutReady);
        end
    end

    logic [1:0]  d_f[21] = '{
        2'd1, 2'd1, 2'd1, 2'd1, 2'd1,
        2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2,
        2'd0, 2'd0, 2'd0, 2'd0,
        2'd2, 2'd3, 2'd3};
    logic [63:0] d_x[21] = '{
        64'hBFF0000000000000, 64'h3FF0000000000001, 64'h400C000000000000,
        64'h3FF0000000000000, 64'hFFF0000000000000,
        64'hFFFFFFFFFFFF0100, 64'hFFFFFFFFFFFF0200, 64'hFFFFFFFFFFFF7C00,
        64'hFFFFFFFFFFFF7E00, 64'hFFFFFFFFFFFF7E01, 64'hFFFFFFFFFFFFFC00,
        64'hFFFFFFFFFFFF0000, 64'hFFFFFFFFFFFF7800, 64'hFFFFFFFFFFFF0400,
        64'h000000003F800000, 64'hFFFFFFFF3F800000, 64'hFFFFFFFF40600000,
        64'hFFFFFFFF00800000,
        64'hFFFFFFFF00003C00, 64'hFFFFFFFFFFFFFFFF, 64'h3FFF000000000000};
    logic [5:0]  d_e[21] = '{
        {1'b1, 5'd0}, 6'd0, 6'd0, {1'b1, 5'd16}, 6'd0,
        {1'b1, 5'd2}, {1'b1, 5'd3}, {1'b1, 5'd30}, {1'b1, 5'd31}, 6'd0, 6'd0,
        6'd0, {1'b1, 5'd28}, {1'b1, 5'd1},
        {1'b1, 5'd31}, {1'b1, 5'd16}, 6'd0, {1'b1, 5'd1},
        {1'b1, 5'd31}, 6'd0, 6'd0};

    initial begin
        logic [63:0] v, x;
        int f, kind, i, b;
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("reset_ovalid", 64'(OutValid), 64'd0);
        chk("reset_hit", 64'(Hit), 64'd0);
        chk("reset_idx", 64'(Idx), 64'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        chk("reset_inready", 64'(InReady), 64'd1);
        @(posedge clk);
        #1;

        send(2'd0, 64'hFFFFFFFF3F800000, {1'b1, 5'd16});
        InValid = 1'b0;
        @(negedge clk);
        chk("lat_early", 64'(OutValid), 64'd0);
        @(negedge clk);
        chk("lat_valid", 64'(OutValid), 64'd1);
        @(posedge clk);
        #1;

        for (int k = 0; k < 21; k++) send(d_f[k], d_x[k], d_e[k]);
        drain();

        rdy_mode = 1;
        for (int k = 0; k < 32; k++) begin
            void'(enc(0, k, v));
            send(2'd0, box(0, v), {1'b1, 5'(k)});
        end
        drain();

        rdy_mode = 2;
        for (int k = 0; k < 400; k++) begin
            f = int'($urandom_range(0, 3));
            kind = int'($urandom_range(0, 3));
            i = int'($urandom_range(0, 31));
            x = {$urandom, $urandom};
            if (kind <= 1 && enc(f, i, v)) begin
                x = box(f, v);
                if (kind == 1) begin
                    b = int'($urandom_range(0, fw(f) - 1));
                    x = x ^ (64'(1) << b);
                end
            end else if (kind == 2) begin
                x = box(f, x);
            end
            send(2'(f), x, model(f, x));
            if ($urandom_range(0, 3) == 0) begin
                InValid = 1'b0;
                @(posedge clk);
                #1;
            end
        end
        drain();

        rdy_mode = 3;
        @(posedge clk);
        #1;
        send(2'd0, 64'hFFFFFFFF3F800000, {1'b1, 5'd16});
        send(2'd0, 64'hFFFFFFFF40000000, {1'b1, 5'd20});
        InValid = 1'b0;
        reset = 1'b1;
        exp_q.delete();
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        chk("flush_ovalid", 64'(OutValid), 64'd0);
        chk("flush_inready", 64'(InReady), 64'd1);
        rdy_mode = 0;
        repeat (5) @(posedge clk);
        #1;
        send(2'd2, 64'hFFFFFFFFFFFF3C00, {1'b1, 5'd16});
        drain();

        chk("queue_empty", 64'(exp_q.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
